// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word-addressed memory responder.
// Each accepted request is answered a fixed LATENCY edges later and held until the initiator takes it.
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      r_state, w_next;
   logic        r_armed;
   logic        r_write;
   logic [15:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_lat_cnt;
   logic [31:0] r_mem [DEPTH];
   logic        w_accept, w_access, w_in_range;
   // r_armed blocks acceptance on the edge that coincides with reset release
   assign req_ready  = (r_state == IDLE) && r_armed;
   assign rsp_valid  = (r_state == RESP);
   assign w_accept   = req_valid && req_ready;
   assign w_access   = (r_state == BUSY) && (r_lat_cnt == 4'd0);
   assign w_in_range = 32'(r_addr) < $unsigned(DEPTH);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_next;
         r_armed <= 1'b1;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? BUSY : IDLE;
         BUSY:    w_next = (r_lat_cnt == 4'd0) ? RESP : BUSY;
         RESP:    w_next = rsp_ready ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_write   <= 1'b0;
         r_addr    <= 16'd0;
         r_wdata   <= 32'd0;
         r_lat_cnt <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write   <= req_write;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_lat_cnt <= 4'(LATENCY - 1);
         end else if (r_state == BUSY && r_lat_cnt != 4'd0) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end
         if (w_access) begin
            rsp_err   <= !w_in_range;
            rsp_rdata <= (w_in_range && !r_write) ? r_mem[r_addr[AW-1:0]] : 32'd0;
         end else if (r_state == RESP && rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
         end
      end
   end
   // Array is deliberately outside reset so contents survive it
   always_ff @(posedge clk) begin
      if (w_access && w_in_range && r_write)
         r_mem[r_addr[AW-1:0]] <= r_wdata;
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY=2 (table + corner sequences)
// and LATENCY=1 back-to-back throughput.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [15:0] req_addr = 16'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic [31:0] rsp_rdata;
   logic        req_valid1 = 1'b0, req_ready1, req_write1 = 1'b0;
   logic [15:0] req_addr1 = 16'd0;
   logic [31:0] req_wdata1 = 32'd0;
   logic        rsp_valid1, rsp_ready1 = 1'b1, rsp_err1;
   logic [31:0] rsp_rdata1;
   int errs = 0, checks = 0, cyc = 0, k1 = 0;
   logic [31:0] exp1 [4] = '{32'h0, 32'h0000000A, 32'h0, 32'h0000000B};

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        er;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Responses of the LATENCY=1 instance must arrive in request order
   always @(negedge clk) begin
      if (rsp_valid1) begin
         if (k1 < 4) chk("l1_rdata", rsp_rdata1, exp1[k1]);
         else begin
            errs++;
            $display("FAIL l1_extra_rsp: got response %0d expected none", k1);
         end
         k1++;
      end
   end

   task automatic txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post_req_ready", 32'(req_ready), 32'h1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, n, t, tprev;
      logic        w1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] a1 [4] = '{16'd10, 16'd10, 16'd11, 16'd11};
      logic [31:0] d1 [4] = '{32'hA, 32'h0, 32'hB, 32'h0};
      tbl[0]  = '{1'b1, 16'h0005, 32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 16'h0005, 32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 16'h0000, 32'h11111111, 32'h0,        1'b0};
      tbl[3]  = '{1'b1, 16'h0100, 32'h00001234, 32'h0,        1'b1};
      tbl[4]  = '{1'b0, 16'h0100, 32'h0,        32'h0,        1'b1};
      tbl[5]  = '{1'b0, 16'h0000, 32'h0,        32'h11111111, 1'b0};
      tbl[6]  = '{1'b1, 16'h00FF, 32'hCAFEF00D, 32'h0,        1'b0};
      tbl[7]  = '{1'b0, 16'h00FF, 32'h0,        32'hCAFEF00D, 1'b0};
      tbl[8]  = '{1'b0, 16'hFFFF, 32'h0,        32'h0,        1'b1};
      tbl[9]  = '{1'b1, 16'h0003, 32'h12345678, 32'h0,        1'b0};
      tbl[10] = '{1'b0, 16'h0003, 32'h0,        32'h12345678, 1'b0};
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      // Request already pending at release: the first edge must not take it
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd7; req_wdata = 32'h77;
      rst = 1'b1;
      @(negedge clk);
      chk("release_no_accept", 32'(req_ready), 32'h1);
      @(negedge clk);
      chk("release_accept_next", 32'(req_ready), 32'h0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("release_busy", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      chk("release_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("release_rsp_err", 32'(rsp_err), 32'h0);
      @(negedge clk);
      chk("release_done", 32'(rsp_valid), 32'h0);
      for (int i = 0; i < 11; i++) begin
         txn(tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
      end
      // Back-pressure: response held, intervening store ignored
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd5; rsp_ready = 1'b0;
      @(negedge clk);
      req_write = 1'b1; req_wdata = 32'h55555555;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("hold_req_ready", 32'(req_ready), 32'h0);
         @(negedge clk);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", 32'(rsp_valid), 32'h0);
      chk("hold_release_rdata", rsp_rdata, 32'h0);
      chk("hold_release_ready", 32'(req_ready), 32'h1);
      txn(1'b0, 16'd5, 32'h0, rd, er, lat);
      chk("hold_ignored_store", rd, 32'hDEADBEEF);
      // Reset while BUSY drops the store
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd3; req_wdata = 32'h0000AAAA;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("abort_rsp_rdata", rsp_rdata, 32'h0);
      chk("abort_rsp_err", 32'(rsp_err), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
      end
      txn(1'b0, 16'd3, 32'h0, rd, er, lat);
      chk("abort_mem_kept", rd, 32'h12345678);
      chk("abort_latency", 32'(lat), 32'd2);
      // LATENCY=1 streaming with req_valid and rsp_ready held high
      tprev = 0;
      for (int i = 0; i < 4; i++) begin
         req_valid1 = 1'b1; req_write1 = w1[i]; req_addr1 = a1[i]; req_wdata1 = d1[i];
         n = 0;
         while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
         t = cyc;
         if (i > 0) chk("l1_spacing", 32'(t - tprev), 32'd3);
         tprev = t;
         @(negedge clk);
      end
      req_valid1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("l1_rsp_count", 32'(k1), 32'd4);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
